// File: rtl/led_pwm_pkg.sv
// led_pwm_pkg: shared constants for the FrontPanel LED PWM driver.
//   NUM_CH / DUTY_W   channel count and duty resolution (duty_word packs 4 x 8 bits)
//   PWM_MAX           last pwm_cnt value before wrap (period = PWM_MAX+1 steps)
//   CTRL_* / STAT_*   bit-field positions inside ctrl_word and status_word
//   fade_state_t      per-channel fade FSM encoding
package led_pwm_pkg;

    localparam int NUM_CH  = 4;
    localparam int DUTY_W  = 8;
    localparam int PWM_MAX = 2**DUTY_W - 2;

    // ctrl_word fields
    localparam int CTRL_EN_LSB   = 0;
    localparam int CTRL_FADE_LSB = 4;
    localparam int CTRL_DIV_LSB  = 8;
    localparam int CTRL_DIV_W    = 8;

    // status_word fields
    localparam int STAT_LED_LSB  = 0;
    localparam int STAT_FADE_LSB = 4;
    localparam int STAT_CNT_LSB  = 8;
    localparam int STAT_PER_LSB  = 16;
    localparam int STAT_PER_W    = 16;

    typedef enum logic [1:0] {
        FADE_IDLE = 2'd0,
        FADE_UP   = 2'd1,
        FADE_DOWN = 2'd2
    } fade_state_t;

endpackage

// File: rtl/led_pwm_channel.sv
// led_pwm_channel: one LED channel -- shadow target, current duty, fade FSM
// and the PWM compare.
//   okClk, rst_n  clock / async active-low reset
//   boundary      last step of the PWM period; shadow registers load here
//   fade_step     shared fade divider fired on this boundary
//   pwm_cnt       current PWM step
//   duty          host target duty (live WireIn slice)
//   en, fade_en   host enables (live WireIn bits)
//   led_on        registered LED drive, 1 = lit
//   fading        fade FSM not idle
//   fade_req      this channel would fade with the words present right now
module led_pwm_channel
    import led_pwm_pkg::*;
(
    input  logic              okClk,
    input  logic              rst_n,
    input  logic              boundary,
    input  logic              fade_step,
    input  logic [DUTY_W-1:0] pwm_cnt,
    input  logic [DUTY_W-1:0] duty,
    input  logic              en,
    input  logic              fade_en,
    output logic              led_on,
    output logic              fading,
    output logic              fade_req
);

    logic [DUTY_W-1:0] target_q, cur_q, cur_nxt, tgt_eff;
    logic              en_q;
    fade_state_t       state_q, state_nxt, dir;

    // Target as it stands after this edge: on a boundary the fresh host word
    // is latched and the fade step in the same cycle already follows it.
    assign tgt_eff  = boundary ? duty : target_q;
    assign fade_req = fade_en && (cur_q != duty);
    assign fading   = (state_q != FADE_IDLE);

    always_comb begin
        dir = FADE_IDLE;
        if (cur_q < tgt_eff)      dir = FADE_UP;
        else if (cur_q > tgt_eff) dir = FADE_DOWN;
    end

    always_comb begin
        cur_nxt   = cur_q;
        state_nxt = state_q;
        if (boundary) begin
            if (!fade_en) begin
                cur_nxt   = tgt_eff;
                state_nxt = FADE_IDLE;
            end else begin
                if (fade_step) begin
                    unique case (dir)
                        FADE_UP:   cur_nxt = cur_q + DUTY_W'(1);
                        FADE_DOWN: cur_nxt = cur_q - DUTY_W'(1);
                        default:   cur_nxt = cur_q;
                    endcase
                end
                // State reflects what remains after this boundary's step.
                if (cur_nxt < tgt_eff)      state_nxt = FADE_UP;
                else if (cur_nxt > tgt_eff) state_nxt = FADE_DOWN;
                else                        state_nxt = FADE_IDLE;
            end
        end
    end

    always_ff @(posedge okClk or negedge rst_n) begin
        if (!rst_n) begin
            target_q <= '0;
            cur_q    <= '0;
            en_q     <= 1'b0;
            state_q  <= FADE_IDLE;
            led_on   <= 1'b0;
        end else begin
            if (boundary) begin
                target_q <= duty;
                en_q     <= en;
            end
            cur_q   <= cur_nxt;
            state_q <= state_nxt;
            // cur <= 255 > any pwm_cnt (max 254), so full duty never blinks.
            led_on  <= en_q && (cur_q > pwm_cnt);
        end
    end

endmodule

// File: rtl/led_pwm_driver.sv
// led_pwm_driver: host-programmed PWM for the four open-drain panel LEDs.
//   okClk        endpoint clock (sole clock)
//   rst_n        asynchronous active-low reset
//   duty_word    ch i target duty in bits [8i+7:8i]
//   ctrl_word    [3:0] enable, [7:4] fade enable, [15:8] fade_div
//   led_on       1 = LED lit (pad pulled low by the wrapper)
//   status_word  [3:0] led_on, [7:4] fading, [15:8] pwm_cnt, [31:16] periods
module led_pwm_driver
    import led_pwm_pkg::*;
#(
    parameter int PWM_DIV = 4
) (
    input  logic              okClk,
    input  logic              rst_n,
    input  logic [31:0]       duty_word,
    input  logic [31:0]       ctrl_word,
    output logic [NUM_CH-1:0] led_on,
    output logic [31:0]       status_word
);

    localparam int PRESC_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

    logic [PRESC_W-1:0]    presc;
    logic [DUTY_W-1:0]     pwm_cnt;
    logic [CTRL_DIV_W-1:0] fade_cnt, fade_div;
    logic [STAT_PER_W-1:0] period_cnt;
    logic                  step_tick, boundary, fade_step, any_req;
    logic [NUM_CH-1:0]     fading, fade_req;
    logic [15:0]           unused_ctrl;

    assign unused_ctrl = ctrl_word[31:16];

    assign step_tick = (presc == PRESC_W'(PWM_DIV - 1));
    assign boundary  = step_tick && (pwm_cnt == DUTY_W'(PWM_MAX));
    // Only consulted on a boundary, where it equals the value being latched.
    assign fade_div  = ctrl_word[CTRL_DIV_LSB +: CTRL_DIV_W];
    assign any_req   = |fade_req;
    // >= rather than == so a shrinking fade_div cannot strand the counter.
    assign fade_step = boundary && any_req && (fade_cnt >= fade_div);

    always_ff @(posedge okClk or negedge rst_n) begin
        if (!rst_n) begin
            presc      <= '0;
            pwm_cnt    <= '0;
            fade_cnt   <= '0;
            period_cnt <= '0;
        end else begin
            presc <= step_tick ? '0 : presc + 1'b1;
            if (step_tick)
                pwm_cnt <= boundary ? '0 : pwm_cnt + 1'b1;
            if (boundary) begin
                period_cnt <= period_cnt + 1'b1;
                if (!any_req || fade_step) fade_cnt <= '0;
                else                       fade_cnt <= fade_cnt + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        led_pwm_channel u_ch (
            .okClk     (okClk),
            .rst_n     (rst_n),
            .boundary  (boundary),
            .fade_step (fade_step),
            .pwm_cnt   (pwm_cnt),
            .duty      (duty_word[DUTY_W*i +: DUTY_W]),
            .en        (ctrl_word[CTRL_EN_LSB + i]),
            .fade_en   (ctrl_word[CTRL_FADE_LSB + i]),
            .led_on    (led_on[i]),
            .fading    (fading[i]),
            .fade_req  (fade_req[i])
        );
    end

    assign status_word[STAT_LED_LSB  +: NUM_CH]     = led_on;
    assign status_word[STAT_FADE_LSB +: NUM_CH]     = fading;
    assign status_word[STAT_CNT_LSB  +: DUTY_W]     = pwm_cnt;
    assign status_word[STAT_PER_LSB  +: STAT_PER_W] = period_cnt;

endmodule

// File: tb/tb_led_pwm_driver.sv
// Scoreboard bench: the stimulus process writes host words mid-period and, just
// before each boundary, pushes the expected per-period LED on-time, fading
// flags and period count from a period-level reference model. The monitor
// measures every period independently and pops/compares.
module tb_led_pwm_driver;

    localparam int N1 = 40;
    localparam int N2 = 10;

    typedef struct packed {
        logic [3:0][8:0] cnt;
        logic [3:0]      fading;
        logic [15:0]     period;
    } exp_t;

    logic        okClk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] duty_word = '0;
    logic [31:0] ctrl_word = '0;
    logic [3:0]  led_on;
    logic [31:0] status_word;

    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];
    int   m_cur[4];
    int   m_fc;

    led_pwm_driver #(.PWM_DIV(1)) dut (
        .okClk       (okClk),
        .rst_n       (rst_n),
        .duty_word   (duty_word),
        .ctrl_word   (ctrl_word),
        .led_on      (led_on),
        .status_word (status_word)
    );

    always #5 okClk = ~okClk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Period-level reference: apply the words present at the boundary.
    task automatic model_boundary(input int k);
        exp_t e;
        bit   active = 0, step = 0;
        int   tgt, div;
        div = int'(ctrl_word[15:8]);
        for (int i = 0; i < 4; i++) begin
            tgt = int'(duty_word[8*i +: 8]);
            if (ctrl_word[4+i] && m_cur[i] != tgt) active = 1;
        end
        if (!active)          m_fc = 0;
        else if (m_fc >= div) begin step = 1; m_fc = 0; end
        else                  m_fc++;
        for (int i = 0; i < 4; i++) begin
            tgt = int'(duty_word[8*i +: 8]);
            if (!ctrl_word[4+i])  m_cur[i] = tgt;
            else if (step)        m_cur[i] += (tgt > m_cur[i]) ? 1 : (tgt < m_cur[i]) ? -1 : 0;
            e.fading[i] = ctrl_word[4+i] && (m_cur[i] != tgt);
            e.cnt[i]    = ctrl_word[i] ? 9'(m_cur[i]) : 9'd0;
        end
        e.period = 16'(k);
        exp_q.push_back(e);
    endtask

    task automatic rand_words(output logic [31:0] d, output logic [31:0] c);
        d = $urandom;
        c = {16'h0, 8'($urandom_range(0, 3)), 8'($urandom)};
    endtask

    task automatic dir_words(input int k, output logic [31:0] d, output logic [31:0] c);
        if (k == 1)            begin d = 32'h0040FF00; c = 32'h0000000F; end
        else if (k == 2)       begin d = 32'h0080FF00; c = 32'h0000000F; end
        else if (k <= 18)      begin d = 32'h0080FF10; c = 32'h0000001F; end
        else if (k <= 21)      begin d = 32'h0080FC10; c = 32'h0000023F; end
        else if (k <= 27)      begin d = 32'h0080FF10; c = 32'h0000023F; end
        else if (k <= 29)      begin d = 32'h0080FF10; c = 32'h00000230; end
        else if (k == N1 - 1)  begin d = 32'hFFFFFFFF; c = 32'h0000000F; end
        else                   rand_words(d, c);
    endtask

    task automatic stimulus(input bit directed, input int n);
        logic [31:0] d, c;
        int w;
        for (int k = 1; k < n; k++) begin
            if (directed) dir_words(k, d, c);
            else          rand_words(d, c);
            w = (directed && k == 2) ? 10 : int'($urandom_range(1, 250));
            for (int j = 1; j <= 254; j++) begin
                @(negedge okClk);
                if (j == w) begin duty_word = d; ctrl_word = c; end
            end
            model_boundary(k);
            @(negedge okClk);
        end
    endtask

    task automatic monitor(input int n);
        exp_t e;
        int   on_cnt[4];
        int   pre[4];
        bit   run[4];
        for (int k = 0; k < n; k++) begin
            for (int c = 0; c < 4; c++) begin on_cnt[c] = 0; pre[c] = 0; run[c] = 1; end
            e = '0;
            for (int j = 0; j < 255; j++) begin
                @(negedge okClk);
                if (j == 0) begin
                    if (exp_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL scoreboard_empty: got 0 entries expected 1 in period %0d", k);
                    end else begin
                        e = exp_q.pop_front();
                        check("period_count", int'(status_word[31:16]), int'(e.period));
                        check("fading", int'(status_word[7:4]), int'(e.fading));
                        check("status_pwm_cnt", int'(status_word[15:8]), 1);
                    end
                end
                for (int c = 0; c < 4; c++) begin
                    if (led_on[c]) on_cnt[c]++;
                    if (run[c] && led_on[c]) pre[c]++;
                    else                     run[c] = 0;
                end
            end
            for (int c = 0; c < 4; c++) begin
                check($sformatf("ch%0d_on_cycles_p%0d", c, k), on_cnt[c], int'(e.cnt[c]));
                check($sformatf("ch%0d_on_prefix_p%0d", c, k), pre[c], int'(e.cnt[c]));
            end
        end
    endtask

    task automatic run_periods(input bit directed, input int n);
        for (int i = 0; i < 4; i++) m_cur[i] = 0;
        m_fc = 0;
        exp_q.delete();
        exp_q.push_back('0);
        fork
            stimulus(directed, n);
            monitor(n);
        join
    endtask

    initial begin
        bit found;
        #3;
        check("reset_led_on", int'(led_on), 0);
        check("reset_status", int'(status_word), 0);
        @(negedge okClk);
        @(negedge okClk);
        rst_n = 1'b1;

        run_periods(1'b1, N1);

        // Reset in the middle of a lit period.
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge okClk);
            if (status_word[15:8] == 8'd100) found = 1;
        end
        check("reach_pwm_100", int'(found), 1);
        check("pre_reset_lit", int'(led_on), 4'hF);
        rst_n = 1'b0;
        #1;
        check("async_reset_led_on", int'(led_on), 0);
        check("async_reset_status", int'(status_word), 0);
        repeat (3) @(negedge okClk);
        check("held_reset_status", int'(status_word), 0);
        rst_n = 1'b1;
        #1;
        check("release_status", int'(status_word), 0);

        run_periods(1'b0, N2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
